// File: rtl/apb_rr_master.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// One transfer in flight at a time; a watchdog ends transfers that stall in ACCESS.
module apb_rr_master #(
    parameter int NREQ    = 2,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_strb,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [AW-1:0]          PADDR,
    output logic [DW-1:0]          PWDATA,
    output logic [DW/8-1:0]        PSTRB,
    input  logic [DW-1:0]          PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int SW  = DW / 8;
    localparam int PW  = (NREQ > 2) ? 2 : 1;
    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // First requester at or above ptr (wrapping); lowest offset wins, so scan downward.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            res = v[idx] ? {1'b1, PW'(idx)} : res;
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_gnt;
    logic [WDW-1:0]    r_wdog;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [AW-1:0]     r_paddr;
    logic [DW-1:0]     r_pwdata;
    logic [SW-1:0]     r_pstrb;
    logic [NREQ-1:0]   r_req_ready;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DW-1:0]     r_rsp_rdata;
    logic              r_rsp_err;

    logic [PW:0]       w_pick;
    logic              w_pick_found;
    logic [PW-1:0]     w_pick_idx;
    logic              w_sel_write;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic [SW-1:0]     w_sel_strb;
    logic              w_wdog_hit;
    logic [PW-1:0]     w_ptr_inc;

    state_t            w_state_nxt;
    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     w_gnt_nxt;
    logic [WDW-1:0]    w_wdog_nxt;
    logic              w_psel_nxt;
    logic              w_penable_nxt;
    logic              w_pwrite_nxt;
    logic [AW-1:0]     w_paddr_nxt;
    logic [DW-1:0]     w_pwdata_nxt;
    logic [SW-1:0]     w_pstrb_nxt;
    logic [NREQ-1:0]   w_req_ready_nxt;
    logic [NREQ-1:0]   w_rsp_valid_nxt;
    logic [DW-1:0]     w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;

    assign w_pick       = rr_pick(req_valid, r_ptr);
    assign w_pick_found = w_pick[PW];
    assign w_pick_idx   = w_pick[PW-1:0];
    assign w_sel_write  = req_write[w_pick_idx];
    assign w_sel_addr   = req_addr[int'(w_pick_idx)*AW +: AW];
    assign w_sel_wdata  = req_wdata[int'(w_pick_idx)*DW +: DW];
    assign w_sel_strb   = req_strb[int'(w_pick_idx)*SW +: SW];
    assign w_wdog_hit   = (TIMEOUT != 0) && !PREADY && (r_wdog == WD_LAST);
    assign w_ptr_inc    = (int'(r_gnt) == NREQ - 1) ? '0 : r_gnt + PW'(1);

    // Next-state, APB phase and response decode
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_wdog_nxt      = r_wdog;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt     = ST_SETUP;
                    w_psel_nxt      = 1'b1;
                    w_gnt_nxt       = w_pick_idx;
                    w_req_ready_nxt = onehot(w_pick_idx);
                    w_pwrite_nxt    = w_sel_write;
                    w_paddr_nxt     = w_sel_addr;
                    w_pwdata_nxt    = w_sel_wdata;
                    w_pstrb_nxt     = w_sel_write ? w_sel_strb : '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_wdog_nxt    = '0;
            end
            ST_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                if (PREADY || w_wdog_hit) begin
                    w_state_nxt     = ST_IDLE;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = onehot(r_gnt);
                    w_ptr_nxt       = w_ptr_inc;
                    w_wdog_nxt      = '0;
                    // A watchdog termination never reports slave data.
                    if (PREADY) begin
                        w_rsp_err_nxt   = PSLVERR;
                        w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
                    end else begin
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end else begin
                    w_wdog_nxt = r_wdog + WDW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer and registered outputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_wdog      <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_wdog      <= w_wdog_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small memory-model APB slave.
module tb_apb_rr_master;

    localparam int NREQ    = 2;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 16;

    logic                 PCLK = 1'b0;
    logic                 PRESET;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_strb;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [AW-1:0]        PADDR;
    logic [DW-1:0]        PWDATA;
    logic [SW-1:0]        PSTRB;
    logic [DW-1:0]        PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    logic [DW-1:0]        mem [0:255];
    int                   acc_cnt = 0;
    int                   slv_wait = 0;
    logic                 slv_stuck = 1'b0;
    logic                 slv_err = 1'b0;
    int                   total = 0;
    int                   bad = 0;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PRDATA  = mem[PADDR];
    assign PREADY  = !slv_stuck && (acc_cnt >= slv_wait);
    assign PSLVERR = slv_err;

    // Slave model: counts ACCESS cycles and commits strobed writes on completion
    always @(posedge PCLK) begin
        acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
        if (PSEL && PENABLE && PREADY && PWRITE) begin
            for (int b = 0; b < SW; b++) begin
                if (PSTRB[b]) mem[PADDR][b*8 +: 8] <= PWDATA[b*8 +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer by requester r, checking SETUP, every ACCESS cycle and the response
    task automatic xfer(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int exp_acc, input logic exp_err,
                        input logic [DW-1:0] exp_rd);
        logic [NREQ-1:0] oh;
        int n;
        oh = '0;
        oh[r] = 1'b1;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_strb[r*SW +: SW] = s;
        tick();
        check_eq("setup_phase", 64'({PSEL, PENABLE}), 64'(2'b10));
        check_eq("req_ready", 64'(req_ready), 64'(oh));
        check_eq("setup_paddr", 64'(PADDR), 64'(a));
        check_eq("setup_pwrite", 64'(PWRITE), 64'(wr));
        check_eq("setup_pstrb", 64'(PSTRB), wr ? 64'(s) : 64'(0));
        req_valid[r] = 1'b0;
        n = 0;
        tick();
        while (PSEL && PENABLE && n < 40) begin
            check_eq("access_paddr", 64'(PADDR), 64'(a));
            if (wr) check_eq("access_pwdata", 64'(PWDATA), 64'(d));
            check_eq("access_no_rsp", 64'(rsp_valid), 64'(0));
            n++;
            tick();
        end
        check_eq("access_len", 64'(n), 64'(exp_acc));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(oh));
        check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check_eq("idle_psel", 64'({PSEL, PENABLE}), 64'(2'b00));
    endtask

    initial begin
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        tick();
        tick();
        check_eq("rst_apb", 64'({PSEL, PENABLE, PWRITE, PADDR, PSTRB}), 64'(0));
        check_eq("rst_pwdata", 64'(PWDATA), 64'(0));
        check_eq("rst_rsp", 64'({req_ready, rsp_valid, rsp_err}), 64'(0));
        check_eq("rst_rdata", 64'(rsp_rdata), 64'(0));
        PRESET = 1'b0;
        tick();

        // Zero-wait write, then read it back
        xfer(0, 1'b1, 8'h05, 32'h0000ABCD, 4'hF, 1, 1'b0, 32'h0);
        xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, 1, 1'b0, 32'h0000ABCD);

        // Two wait states
        slv_wait = 2;
        xfer(1, 1'b1, 8'h0F, 32'h00FF00FF, 4'hF, 3, 1'b0, 32'h0);
        slv_wait = 0;

        // Watchdog with requester 1 pending, then requester 1 served next
        slv_stuck = 1'b1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[AW +: AW] = 8'h0F;
        xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, TIMEOUT, 1'b1, 32'h0);
        slv_stuck = 1'b0;
        xfer(1, 1'b0, 8'h0F, 32'h0, 4'h0, 1, 1'b0, 32'h00FF00FF);

        // Slave error
        slv_err = 1'b1;
        xfer(1, 1'b1, 8'h30, 32'hDEAD0001, 4'hF, 1, 1'b1, 32'h0);
        slv_err = 1'b0;

        // Both requesting continuously: grants alternate, one response every 3 cycles
        req_valid = 2'b11;
        req_write = 2'b01;
        req_addr  = {8'h0F, 8'h0A};
        req_wdata = {32'h0, 32'h12345678};
        req_strb  = {4'h0, 4'hF};
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_rdy = '0;
            exp_rsp = '0;
            if (c % 3 == 1) exp_rdy = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (c % 3 == 0) exp_rsp = (((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10;
            check_eq("arb_ready", 64'(req_ready), 64'(exp_rdy));
            check_eq("arb_rsp", 64'(rsp_valid), 64'(exp_rsp));
            if (exp_rsp == 2'b10) check_eq("arb_rdata", 64'(rsp_rdata), 64'(32'h00FF00FF));
        end
        req_valid = '0;

        // Move the pointer to 1, then reset in the middle of requester 1's ACCESS
        xfer(0, 1'b0, 8'h0A, 32'h0, 4'h0, 1, 1'b0, 32'h12345678);
        slv_stuck = 1'b1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[AW +: AW] = 8'h40;
        tick();
        check_eq("rst_mid_ready", 64'(req_ready), 64'(2'b10));
        req_valid[1] = 1'b0;
        tick();
        check_eq("rst_mid_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        PRESET = 1'b1;
        #1;
        check_eq("rst_async_drop", 64'({PSEL, PENABLE}), 64'(2'b00));
        tick();
        check_eq("rst_no_rsp", 64'(rsp_valid), 64'(0));
        slv_stuck = 1'b0;
        req_valid = 2'b11;
        PRESET = 1'b0;
        tick();
        check_eq("rst_first_grant", 64'(req_ready), 64'(2'b01));
        req_valid = '0;
        tick();
        tick();
        check_eq("rst_first_rsp", 64'(rsp_valid), 64'(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
